data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer in front of the single-port word data memory.
//  Port 0 serves the CPU load/store path; port 1 serves the debug/DMA loader.
//  Range-checks and aligns byte addresses, then drives the memory for exactly one cycle per access.
//  Returns registered read data, or an error, through a valid/ready response handshake.
// PARAMETERS
//  DATA_W     32        data width of memory and ports
//  ADDR_W     32        byte-address width
//  MEM_TOP    32'h3ffc  byte address of the highest memory word (maps to index MEM_WORDS-1)
//  MEM_WORDS  1024      number of words in the memory
// PORTS
//  clk          in   1       single clock; everything is on posedge
//  rst_n        in   1       synchronous reset, active-low
//  pN_req_valid in   1       N=0,1: request present
//  pN_req_ready out  1       request accepted this cycle (valid&&ready = accept)
//  pN_req_we    in   1       1 = store, 0 = load
//  pN_req_addr  in   ADDR_W  byte address
//  pN_req_wdata in   DATA_W  store data
//  pN_rsp_valid out  1       response available
//  pN_rsp_ready in   1       requester takes response
//  pN_rsp_rdata out  DATA_W  load data (0 for stores and errors)
//  pN_rsp_err   out  1       address out of range or not 4-byte aligned
//  mem_we       out  1       memory write enable
//  mem_addr     out  ADDR_W  byte address to memory (memory does its own offset)
//  mem_din      out  DATA_W  memory write data
//  mem_dout     in   DATA_W  memory read data (combinational from mem_addr)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; every ready, rsp_valid, rsp_err and mem_we = 0;
//   rsp_rdata, mem_addr and mem_din = 0; last_grant=1, so port 0 wins the first tie.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. Reset mid-operation aborts it: no write, no response.
//  IDLE: pN_req_ready is combinational, high for the winner only.
//   - One port valid: that port wins.
//   - Both valid: the port != last_grant wins.
//   - On accept: latch we/addr/wdata/port, set last_grant=port, compute err, go to ACCESS.
//   - No valid: stay in IDLE.
//  err = (addr[1:0]!=0) || addr>MEM_TOP || addr<MEM_TOP-4*(MEM_WORDS-1).
//   Unsigned compare; do not wrap on subtraction.
//  ACCESS (exactly 1 cycle):
//   - mem_addr = latched addr.
//   - mem_we = latched we && !err; mem_din = latched wdata.
//   - Load without err: capture mem_dout into rsp_rdata at the closing posedge.
//   - err: mem_we=0, rdata=0, rsp_err=1.
//   - Go to RESP.
//  RESP: pN_rsp_valid=1 for the latched port only.
//   - rdata and err are held stable until rsp_ready.
//   - rsp_ready=1: IDLE next cycle, valid drops.
//   - No new request is accepted in RESP (one outstanding access).
//  Outside ACCESS: mem_we=0; mem_addr/mem_din hold their last value.
//  Latency: accept at cycle N, memory access N+1, rsp_valid N+2 (rsp_ready tied 1 gives 3 cycles/access).
//  A requester may keep req_valid high across RESP; it is re-arbitrated in IDLE, and round-robin
//   guarantees alternation when both ports are continuously valid.
//  Stores also produce a response (rdata=0); the write is committed at the posedge ending ACCESS.
// STRUCTURE
//  Shared package dmem_pkg: state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2),
//   MEM_TOP/MEM_WORDS defaults, function addr_ok(addr) used here and by the bench.
//  One natural sub-module: rr_arb2 (2-way round-robin grant from valid + last_grant).
//  Remainder flat: FSM, request latch, response registers.
// TESTING
//  1. Reset, p0 store 0x3ffc<-0xDEADBEEF, then p0 load 0x3ffc -> rdata 0xDEADBEEF, err 0;
//     mem_we high exactly one cycle.
//  2. p0 and p1 valid every cycle (loads 0x3ff8 / 0x3ff4) -> grants alternate 0,1,0,1; first grant p0.
//  3. p1 load 0x3ffe (unaligned), 0x4000 and 0x2ffc -> err 1, rdata 0, mem_we never asserted.
//  4. Boundaries: store/load 0x3000 (index 0) and 0x3ffc (index 1023) -> data round-trips, err 0.
//  5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable; p1 req_ready stays 0.
//  6. Deassert rst_n during ACCESS of a store -> memory word unchanged; all outputs at reset values next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory map defaults, address check.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - arbiter sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   *_DEF      - default widths and memory map
//   addr_ok()  - word-aligned and inside [bottom, top], with bottom clamped at 0
package dmem_pkg;

  localparam int          DATA_W_DEF    = 32;
  localparam int          ADDR_W_DEF    = 32;
  localparam logic [31:0] MEM_TOP_DEF   = 32'h0000_3ffc;
  localparam int          MEM_WORDS_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Byte address is legal when 4-byte aligned and inside the word window that
  // ends at top. All arithmetic is 64-bit unsigned so the lower bound cannot
  // wrap; a window larger than top simply starts at address 0.
  function automatic logic addr_ok(
    input logic [63:0] addr,
    input logic [63:0] top   = 64'(MEM_TOP_DEF),
    input logic [63:0] words = 64'(MEM_WORDS_DEF)
  );
    logic [63:0] span;
    logic [63:0] bottom;
    span   = (words == 64'd0) ? 64'd0 : 64'd4 * (words - 64'd1);
    bottom = (top >= span) ? (top - span) : 64'd0;
    return (addr[1:0] == 2'b00) && (addr <= top) && (addr >= bottom);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data-memory arbiter: request and response handshakes.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
//
// Signals:
//   req_valid/req_ready  request handshake, accept on valid && ready
//   req_we               1 = store, 0 = load
//   req_addr/req_wdata   byte address and store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata/rsp_err    load data (0 for stores and errors) and address error flag
// Modports: master = requester, slave = arbiter.
interface data_mem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed and updates last_grant.
//
// Ports:
//   valid[1:0]  in   request present per port
//   last_grant  in   index of the port that won the previous accept
//   grant[1:0]  out  one-hot grant (all zero when nothing is valid)
//   grant_idx   out  index of the granted port (0 when nothing is valid)
//   any_valid   out  at least one port is requesting
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx,
  output logic       any_valid
);

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (valid)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        // Tie: hand the grant to whichever port did not win last time.
        grant_idx = ~last_grant;
        grant     = last_grant ? 2'b01 : 2'b10;
      end
      default: begin
        grant     = 2'b00;
        grant_idx = 1'b0;
      end
    endcase
  end

  assign any_valid = |valid;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port word memory between CPU (p0) and loader (p1).
// Latency: accept at cycle N, memory access at N+1, response valid at N+2 (3 cycles/access at full rate).
// Backpressure: one access outstanding; no request is accepted until the response is taken (rsp_ready).
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   p0, p1                requester ports (data_mem_arbiter_if.slave)
//   mem_we                write strobe, high only during ACCESS of an in-range store
//   mem_addr, mem_din     byte address / write data, loaded on accept and held afterwards
//   mem_dout              combinational read data for mem_addr
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MEM_TOP = MEM_TOP_DEF,
  parameter int              MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave p0,
  data_mem_arbiter_if.slave p1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t state_q;
  state_t state_d;

  logic              last_grant_q;
  logic              lat_port_q;
  logic              lat_we_q;
  logic              lat_err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        grant;
  logic              grant_idx;
  logic              any_valid;
  logic              accept;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_err;
  logic              rsp_ready_sel;
  logic              in_resp;

  rr_arb2 u_arb (
    .valid      ({p1.req_valid, p0.req_valid}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  // Winner's request fields, used only on the accepting edge.
  assign win_we    = grant_idx ? p1.req_we    : p0.req_we;
  assign win_addr  = grant_idx ? p1.req_addr  : p0.req_addr;
  assign win_wdata = grant_idx ? p1.req_wdata : p0.req_wdata;
  assign win_err   = !addr_ok(64'(win_addr), 64'(MEM_TOP), 64'(MEM_WORDS));

  assign accept        = (state_q == IDLE) && any_valid;
  assign rsp_ready_sel = lat_port_q ? p1.rsp_ready : p0.rsp_ready;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and response data.
  // mem_addr/mem_din double as the latched address and store data: they are
  // loaded on accept, presented during ACCESS and simply hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_port_q   <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_err_q    <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_idx;
        lat_port_q   <= grant_idx;
        lat_we_q     <= win_we;
        lat_err_q    <= win_err;
        mem_addr     <= win_addr;
        mem_din      <= win_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (!lat_we_q && !lat_err_q) ? mem_dout : '0;
      end
    end
  end

  // Handshake and strobe outputs are qualified with rst_n so that a reset
  // arriving mid-access suppresses the write and any response in that cycle.
  assign mem_we  = rst_n && (state_q == ACCESS) && lat_we_q && !lat_err_q;
  assign in_resp = rst_n && (state_q == RESP);

  assign p0.req_ready = rst_n && (state_q == IDLE) && grant[0];
  assign p1.req_ready = rst_n && (state_q == IDLE) && grant[1];

  assign p0.rsp_valid = in_resp && !lat_port_q;
  assign p1.rsp_valid = in_resp &&  lat_port_q;

  // Response payload is driven only toward the port being answered.
  assign p0.rsp_rdata = p0.rsp_valid ? rdata_q : '0;
  assign p1.rsp_rdata = p1.rsp_valid ? rdata_q : '0;
  assign p0.rsp_err   = p0.rsp_valid && lat_err_q;
  assign p1.rsp_err   = p1.rsp_valid && lat_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares every completed response handshake.
// Includes a behavioural 1024-word memory at byte 0x3000..0x3ffc.
module tb_data_mem_arbiter;
  import dmem_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] TOP  = 32'h0000_3ffc;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if p0_if ();
  data_mem_arbiter_if p1_if ();

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  data_mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0       (p0_if),
    .p1       (p1_if),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  bit          mem_loaded = 1'b0;

  function automatic logic in_mem(input logic [31:0] a);
    return (a >= BASE) && (a <= TOP);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off);
  endfunction

  // Out-of-window reads return a non-zero pattern so a missing rdata clear shows up.
  always_comb mem_dout = in_mem(mem_addr) ? mem[word_idx(mem_addr)] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_we && in_mem(mem_addr)) begin
      mem[word_idx(mem_addr)] <= mem_din;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   we_cnt = 0;
  int   grant_log[$];
  int   acc_cyc0 = 0;
  int   acc_cyc1 = 0;
  logic prev_vld0 = 1'b0;
  logic prev_vld1 = 1'b0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  function automatic void check_rsp(input int p, input logic [31:0] rd, input logic er);
    exp_t e;
    if (p == 0 && exp_q0.size() == 0 || p == 1 && exp_q1.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL p%0d unexpected response: got rdata 0x%08h err %0b, expected none", p, rd, er);
    end else begin
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("p%0d rsp_rdata", p), rd, e.rdata);
      check($sformatf("p%0d rsp_err", p), 32'(er), 32'(e.err));
    end
  endfunction

  always @(negedge clk) begin
    if (p0_if.req_valid && p0_if.req_ready) begin
      grant_log.push_back(0);
      acc_cyc0 = cyc;
    end
    if (p1_if.req_valid && p1_if.req_ready) begin
      grant_log.push_back(1);
      acc_cyc1 = cyc;
    end
    if (mem_we) we_cnt++;
    if (p0_if.rsp_valid && !prev_vld0) check("p0 accept-to-valid latency", 32'(cyc - acc_cyc0), 32'd2);
    if (p1_if.rsp_valid && !prev_vld1) check("p1 accept-to-valid latency", 32'(cyc - acc_cyc1), 32'd2);
    prev_vld0 = p0_if.rsp_valid;
    prev_vld1 = p1_if.rsp_valid;
    if (p0_if.rsp_valid && p0_if.rsp_ready) check_rsp(0, p0_if.rsp_rdata, p0_if.rsp_err);
    if (p1_if.rsp_valid && p1_if.rsp_ready) check_rsp(1, p1_if.rsp_rdata, p1_if.rsp_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic en, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_if.req_valid = en; p0_if.req_we = we; p0_if.req_addr = a; p0_if.req_wdata = d;
    end else begin
      p1_if.req_valid = en; p1_if.req_we = we; p1_if.req_addr = a; p1_if.req_wdata = d;
    end
  endtask

  task automatic expect_rsp(input int p, input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Waits (bounded) for the port's request to be accepted, then drops req_valid.
  task automatic wait_accept(input int p, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? (p0_if.req_valid && p0_if.req_ready) : (p1_if.req_valid && p1_if.req_ready);
    end
    check({name, " accepted"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = (exp_q0.size() == 0) && (exp_q1.size() == 0);
    end
    check({name, " responses drained"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic access(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic er, input string name);
    drive(p, 1'b1, we, a, d);
    expect_rsp(p, rd, er);
    wait_accept(p, name);
    wait_drain(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " p0 req_ready"}, 32'(p0_if.req_ready), 32'd0);
    check({tag, " p1 req_ready"}, 32'(p1_if.req_ready), 32'd0);
    check({tag, " p0 rsp_valid"}, 32'(p0_if.rsp_valid), 32'd0);
    check({tag, " p1 rsp_valid"}, 32'(p1_if.rsp_valid), 32'd0);
    check({tag, " p0 rsp_err"},   32'(p0_if.rsp_err),   32'd0);
    check({tag, " p0 rsp_rdata"}, p0_if.rsp_rdata,      32'd0);
    check({tag, " mem_we"},       32'(mem_we),          32'd0);
    check({tag, " mem_addr"},     mem_addr,             32'd0);
    check({tag, " mem_din"},      mem_din,              32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int we_base;
    int gl_base;
    int a0;
    int a1;
    int want_grant[4];
    bit seen;

    want_grant[0] = 0; want_grant[1] = 1; want_grant[2] = 0; want_grant[3] = 1;
    drive(0, 1'b1, 1'b0, TOP, 32'h0);   // request held during reset must not be accepted
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;

    // 1. reset values, then p0 store/load at the top word
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    we_base = we_cnt;
    access(0, 1'b1, TOP, 32'hDEAD_BEEF, 32'h0, 1'b0, "t1 store 0x3ffc");
    check("t1 mem_we cycles for store", 32'(we_cnt - we_base), 32'd1);
    access(0, 1'b0, TOP, 32'h0, 32'hDEAD_BEEF, 1'b0, "t1 load 0x3ffc");

    // 2. both ports continuously valid after reset: p0 first, then alternation
    do_reset();
    gl_base = grant_log.size();
    drive(0, 1'b1, 1'b0, 32'h3ff8, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h3ff4, 32'h0);
    expect_rsp(0, 32'h1000_03FE, 1'b0);
    expect_rsp(0, 32'h1000_03FE, 1'b0);
    expect_rsp(1, 32'h1000_03FD, 1'b0);
    expect_rsp(1, 32'h1000_03FD, 1'b0);
    a0 = 0;
    a1 = 0;
    for (int i = 0; i < 60 && (a0 < 2 || a1 < 2); i++) begin
      @(negedge clk);
      if (p0_if.req_valid && p0_if.req_ready) a0++;
      if (p1_if.req_valid && p1_if.req_ready) a1++;
      @(posedge clk); #1;
      if (a0 >= 2) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (a1 >= 2) drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    wait_drain("t2 alternating loads");
    check("t2 grant count", 32'(grant_log.size() - gl_base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (grant_log.size() > gl_base + k)
        check($sformatf("t2 grant #%0d port", k), 32'(grant_log[gl_base + k]), 32'(want_grant[k]));
    end

    // 3. p1 errors: unaligned, above top, below bottom; an error store never writes
    we_base = we_cnt;
    access(1, 1'b0, 32'h3ffe, 32'h0, 32'h0, 1'b1, "t3 load 0x3ffe");
    access(1, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, "t3 load 0x4000");
    access(1, 1'b0, 32'h2ffc, 32'h0, 32'h0, 1'b1, "t3 load 0x2ffc");
    access(1, 1'b1, 32'h4000, 32'h1234_5678, 32'h0, 1'b1, "t3 store 0x4000");
    check("t3 mem_we cycles for error accesses", 32'(we_cnt - we_base), 32'd0);

    // 4. first and last word round-trip across ports
    we_base = we_cnt;
    access(0, 1'b1, BASE, 32'hCAFE_F00D, 32'h0, 1'b0, "t4 p0 store 0x3000");
    access(1, 1'b1, TOP,  32'h0BAD_F00D, 32'h0, 1'b0, "t4 p1 store 0x3ffc");
    check("t4 mem_we cycles for two stores", 32'(we_cnt - we_base), 32'd2);
    access(1, 1'b0, BASE, 32'h0, 32'hCAFE_F00D, 1'b0, "t4 p1 load 0x3000");
    access(0, 1'b0, TOP,  32'h0, 32'h0BAD_F00D, 1'b0, "t4 p0 load 0x3ffc");

    // 5. p0 stalls its response for 5 cycles while p1 waits
    p0_if.rsp_ready = 1'b0;
    drive(0, 1'b1, 1'b0, BASE, 32'h0);
    expect_rsp(0, 32'hCAFE_F00D, 1'b0);
    wait_accept(0, "t5 p0 load 0x3000");
    drive(1, 1'b1, 1'b0, 32'h3ff4, 32'h0);
    expect_rsp(1, 32'h1000_03FD, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = p0_if.rsp_valid;
    end
    check("t5 p0 rsp_valid reached", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5 stall %0d p0 rsp_valid", i), 32'(p0_if.rsp_valid), 32'd1);
      check($sformatf("t5 stall %0d p0 rsp_rdata", i), p0_if.rsp_rdata, 32'hCAFE_F00D);
      check($sformatf("t5 stall %0d p1 req_ready", i), 32'(p1_if.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    p0_if.rsp_ready = 1'b1;
    wait_accept(1, "t5 p1 load 0x3ff4");
    wait_drain("t5 stall");

    // 6. reset during the ACCESS cycle of a store aborts it
    drive(0, 1'b1, 1'b1, 32'h3ff0, 32'h5555_5555);
    wait_accept(0, "t6 p0 store 0x3ff0");
    rst_n = 1'b0;
    @(negedge clk);
    check("t6 mem_we during reset access", 32'(mem_we), 32'd0);
    @(negedge clk);
    check_reset_outputs("t6 after reset");
    check("t6 word 0x3ff0 unchanged", mem[1020], 32'h1000_03FC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(0, 1'b0, 32'h3ff0, 32'h0, 32'h1000_03FC, 1'b0, "t6 p0 load 0x3ff0");

    check("p0 expected responses left", 32'(exp_q0.size()), 32'd0);
    check("p1 expected responses left", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
